// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: request/result bundle between the EX-stage decoder side and the
// HI/LO multiply/divide unit. Signal names match the original flat port list.
interface ex_muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, div_by_zero, HI, LO
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, div_by_zero, HI, LO
    );
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle multiply/divide unit owning the HI/LO registers.
// MULT/MULTU: shift-add, one multiplier bit per cycle.
// DIV/DIVU: restoring division, one quotient bit per cycle.
// Signed ops work on magnitudes and fix the sign at the final write.
// Build option MULDIV_FAST_MUL_EN: single-cycle combinational multiply.
module ex_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input logic        clk_in,
    input logic        rst_in,
    ex_muldiv_if.slave bus
);
    localparam int unsigned   CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL_RUN,
        S_DIV_RUN
    } state_t;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101,
        OP_NOP6  = 3'b110,
        OP_NOP7  = 3'b111
    } op_t;

    state_t             state_q, state_d;
    op_t                op_w;
    logic               accept;
    logic               signed_op;
    logic [WIDTH-1:0]   a_mag_in, b_mag_in;

    logic [WIDTH-1:0]   a_mag_q, b_mag_q;
    logic               sgn_a_q, sgn_b_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q, dbz_q;

    logic               cnt_last;
    logic               mul_last;
    logic [2*WIDTH-1:0] mul_mag, mul_res;
`ifndef MULDIV_FAST_MUL_EN
    logic [WIDTH-1:0]   mul_addend;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
`endif
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff, div_rem;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH-1:0]   quo_res, rem_res, a_orig;
    logic               div_zero;

    // Decode the request and form operand magnitudes for signed ops.
    always_comb begin
        op_w      = op_t'(bus.op);
        accept    = (state_q == S_IDLE) && bus.start && !bus.flush;
        signed_op = (op_w == OP_MULT) || (op_w == OP_DIV);
        a_mag_in  = (signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        b_mag_in  = (signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    end

    // Per-cycle multiply/divide step and the sign-corrected final results.
    always_comb begin
        cnt_last = (cnt_q == LAST_CNT);

`ifdef MULDIV_FAST_MUL_EN
        mul_last = 1'b1;
        mul_mag  = {{WIDTH{1'b0}}, a_mag_q} * {{WIDTH{1'b0}}, b_mag_q};
`else
        // acc_q = {partial product, remaining multiplier bits}; the carry out
        // of the add lands in the MSB as the whole accumulator shifts right.
        mul_last   = cnt_last;
        mul_addend = acc_q[0] ? a_mag_q : '0;
        mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
        mul_next   = {mul_sum, acc_q[WIDTH-1:1]};
        mul_mag    = mul_next;
`endif
        mul_res = (sgn_a_q ^ sgn_b_q) ? -mul_mag : mul_mag;

        // acc_q = {partial remainder, dividend bits still to shift in}; the
        // remainder stays below the divisor, so the difference fits WIDTH bits.
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_ge    = (div_shift >= {1'b0, b_mag_q});
        div_diff  = div_shift[WIDTH-1:0] - b_mag_q;
        div_rem   = div_ge ? div_diff : div_shift[WIDTH-1:0];
        div_next  = {div_rem, acc_q[WIDTH-2:0], div_ge};

        quo_res  = (sgn_a_q ^ sgn_b_q) ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
        rem_res  = sgn_a_q ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
        a_orig   = sgn_a_q ? -a_mag_q : a_mag_q;
        div_zero = (b_mag_q == '0);
    end

    // FSM state register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: flush wins over everything, including a new start.
    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        case (op_w)
                            OP_MULT, OP_MULTU: state_d = S_MUL_RUN;
                            OP_DIV, OP_DIVU:   state_d = S_DIV_RUN;
                            default:           state_d = S_IDLE;
                        endcase
                    end
                end
                S_MUL_RUN: if (mul_last) state_d = S_IDLE;
                S_DIV_RUN: if (cnt_last) state_d = S_IDLE;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    // FSM outputs and architectural register views.
    always_comb begin
        bus.busy        = (state_q != S_IDLE);
        bus.done        = done_q;
        bus.div_by_zero = dbz_q;
        bus.HI          = hi_q;
        bus.LO          = lo_q;
    end

    // Datapath: operand latch, iteration, HI/LO write and status flags.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            a_mag_q <= '0;
            b_mag_q <= '0;
            sgn_a_q <= 1'b0;
            sgn_b_q <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.flush) begin
                cnt_q <= '0;
            end else if (accept) begin
                cnt_q   <= '0;
                a_mag_q <= a_mag_in;
                b_mag_q <= b_mag_in;
                sgn_a_q <= signed_op & bus.a[WIDTH-1];
                sgn_b_q <= signed_op & bus.b[WIDTH-1];
                case (op_w)
                    OP_MULT, OP_MULTU: begin
                        acc_q <= {{WIDTH{1'b0}}, b_mag_in};
                        dbz_q <= 1'b0;
                    end
                    OP_DIV, OP_DIVU: begin
                        acc_q <= {{WIDTH{1'b0}}, a_mag_in};
                    end
                    OP_MTHI: begin
                        hi_q   <= bus.a;
                        done_q <= 1'b1;
                        dbz_q  <= 1'b0;
                    end
                    OP_MTLO: begin
                        lo_q   <= bus.a;
                        done_q <= 1'b1;
                        dbz_q  <= 1'b0;
                    end
                    default: begin
                        dbz_q <= 1'b0;
                    end
                endcase
            end else begin
                case (state_q)
                    S_MUL_RUN: begin
`ifndef MULDIV_FAST_MUL_EN
                        acc_q <= mul_next;
`endif
                        cnt_q <= cnt_q + CW'(1);
                        if (mul_last) begin
                            hi_q   <= mul_res[2*WIDTH-1:WIDTH];
                            lo_q   <= mul_res[WIDTH-1:0];
                            done_q <= 1'b1;
                            cnt_q  <= '0;
                        end
                    end
                    S_DIV_RUN: begin
                        acc_q <= div_next;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_last) begin
                            if (div_zero) begin
                                hi_q <= a_orig;
                                lo_q <= '1;
                            end else begin
                                hi_q <= rem_res;
                                lo_q <= quo_res;
                            end
                            dbz_q  <= div_zero;
                            done_q <= 1'b1;
                            cnt_q  <= '0;
                        end
                    end
                    default: begin
                        cnt_q <= '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed vectors with hand-computed HI/LO, latency and flag values.
module tb_ex_muldiv;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    ex_muldiv_if #(.WIDTH(32)) bus ();

    ex_muldiv #(.WIDTH(32)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus.slave)
    );

    localparam logic [2:0] MULT  = 3'b000;
    localparam logic [2:0] MULTU = 3'b001;
    localparam logic [2:0] DIV   = 3'b010;
    localparam logic [2:0] DIVU  = 3'b011;
    localparam logic [2:0] MTHI  = 3'b100;
    localparam logic [2:0] MTLO  = 3'b101;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 32;
`endif
    localparam int DIV_LAT = 32;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, count busy cycles after the accept edge, expect done next.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int lat);
        int n;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 200) begin
            step();
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'(lat));
        check({tag, " done"}, 64'(bus.done), 64'd1);
    endtask

    task automatic check_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        check({tag, " HI"}, 64'(bus.HI), 64'(hi));
        check({tag, " LO"}, 64'(bus.LO), 64'(lo));
    endtask

    task automatic done_falls(input string tag);
        step();
        check({tag, " done pulse"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        int dcount;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = 3'b000;
        bus.a     = '0;
        bus.b     = '0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset dbz", 64'(bus.div_by_zero), 64'd0);
        check_hilo("reset", 32'h0, 32'h0);
        step();

        run_op("multu max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
        check_hilo("multu max", 32'hFFFF_FFFE, 32'h0000_0001);
        done_falls("multu max");

        run_op("mult -3*5", MULT, 32'hFFFF_FFFD, 32'd5, MUL_LAT);
        check_hilo("mult -3*5", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        done_falls("mult -3*5");

        run_op("div -7/2", DIV, 32'hFFFF_FFF9, 32'd2, DIV_LAT);
        check_hilo("div -7/2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        check("div -7/2 dbz", 64'(bus.div_by_zero), 64'd0);
        done_falls("div -7/2");

        run_op("divu 7/0", DIVU, 32'd7, 32'd0, DIV_LAT);
        check_hilo("divu 7/0", 32'd7, 32'hFFFF_FFFF);
        check("divu 7/0 dbz", 64'(bus.div_by_zero), 64'd1);
        done_falls("divu 7/0");

        run_op("mtlo 0", MTLO, 32'd0, 32'd0, 0);
        check("mtlo dbz cleared", 64'(bus.div_by_zero), 64'd0);
        check_hilo("mtlo 0", 32'd7, 32'd0);
        done_falls("mtlo 0");

        run_op("mthi", MTHI, 32'h1234_5678, 32'd0, 0);
        check_hilo("mthi", 32'h1234_5678, 32'd0);
        done_falls("mthi");

        run_op("div min/-1", DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT);
        check_hilo("div min/-1", 32'h0, 32'h8000_0000);
        check("div min/-1 dbz", 64'(bus.div_by_zero), 64'd0);
        done_falls("div min/-1");

        run_op("div 7/-2", DIV, 32'd7, 32'hFFFF_FFFE, DIV_LAT);
        check_hilo("div 7/-2", 32'd1, 32'hFFFF_FFFD);
        done_falls("div 7/-2");

        // Back-to-back: the next op is offered in the done cycle.
        run_op("divu 100/7", DIVU, 32'd100, 32'd7, DIV_LAT);
        check_hilo("divu 100/7", 32'd2, 32'd14);
        run_op("b2b multu 3*4", MULTU, 32'd3, 32'd4, MUL_LAT);
        check_hilo("b2b multu 3*4", 32'd0, 32'd12);
        done_falls("b2b multu 3*4");

        run_op("mult min*min", MULT, 32'h8000_0000, 32'h8000_0000, MUL_LAT);
        check_hilo("mult min*min", 32'h4000_0000, 32'h0);
        done_falls("mult min*min");

        run_op("div -7/0", DIV, 32'hFFFF_FFF9, 32'd0, DIV_LAT);
        check_hilo("div -7/0", 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        check("div -7/0 dbz", 64'(bus.div_by_zero), 64'd1);
        done_falls("div -7/0");

        // Flush mid-divide with start held (and retargeted to MTHI) throughout.
        bus.op    = DIV;
        bus.a     = 32'd100;
        bus.b     = 32'd3;
        bus.start = 1'b1;
        step();
        check("flush run busy", 64'(bus.busy), 64'd1);
        bus.op = MTHI;
        bus.a  = 32'hDEAD_BEEF;
        repeat (9) step();
        check("start ignored while busy", 64'(bus.HI), 64'hFFFF_FFF9);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        bus.start = 1'b0;
        check("flush busy", 64'(bus.busy), 64'd0);
        check("flush done", 64'(bus.done), 64'd0);
        check_hilo("flush", 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        check("flush dbz kept", 64'(bus.div_by_zero), 64'd1);
        dcount = 0;
        repeat (40) begin
            step();
            if (bus.done === 1'b1) dcount++;
        end
        check("flush no later done", 64'(dcount), 64'd0);
        check_hilo("flush later", 32'hFFFF_FFF9, 32'hFFFF_FFFF);

        // Flush in IDLE beats a simultaneous start.
        bus.op    = MTHI;
        bus.a     = 32'h0000_0BAD;
        bus.start = 1'b1;
        bus.flush = 1'b1;
        step();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("idle flush done", 64'(bus.done), 64'd0);
        check_hilo("idle flush", 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        step();
        check("idle flush done later", 64'(bus.done), 64'd0);

        // Asynchronous reset in the middle of a MULTU.
        bus.op    = MULTU;
        bus.a     = 32'hFFFF_FFFF;
        bus.b     = 32'hFFFF_FFFF;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("multu accept busy", 64'(bus.busy), 64'd1);
        check("multu accept dbz cleared", 64'(bus.div_by_zero), 64'd0);
        repeat (4) step();
        rst = 1'b1;
        #1;
        check("async rst busy", 64'(bus.busy), 64'd0);
        check_hilo("async rst", 32'h0, 32'h0);
        #1 rst = 1'b0;
        dcount = 0;
        repeat (40) begin
            step();
            if (bus.done === 1'b1) dcount++;
        end
        check("rst no later done", 64'(dcount), 64'd0);
        check_hilo("rst later", 32'h0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, sitting beside the ALU in the EX stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO operations from the decoder. It raises `busy` so the pipeline controller stalls dependent HI/LO reads, and it writes HI/LO atomically on completion. It supersedes the HI/LO source path feeding the ALU's second operand.

## Interface
Parameters:
- `WIDTH`, default 32: operand and HI/LO width. Must be even and ≥ 4.

Ports:
- `clk_in`, input, 1: clock, rising edge.
- `rst_in`, input, 1: reset, asynchronous, active-high.
- `start`, input, 1: request; sampled only while `busy`=0.
- `op`, input, 3: operation select.
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
  - 110 and 111 are NOP: accepted, with no effect and no `done`.
- `a`, input, WIDTH: operand A (RD1); dividend / multiplicand / move source.
- `b`, input, WIDTH: operand B (RD2); divisor / multiplier.
- `flush`, input, 1: abort the in-flight operation (branch mispredict or exception).
- `busy`, output, 1: operation in progress; the new op is not accepted.
- `done`, output, 1: one-cycle pulse; HI/LO hold the new result in this cycle.
- `div_by_zero`, output, 1: the last completed DIV/DIVU had `b`=0.
- `HI`, output, WIDTH: HI register.
- `LO`, output, WIDTH: LO register.

## Operation
- FSM states: IDLE, MUL_RUN, DIV_RUN.
- Iteration counter is $clog2(WIDTH+1) bits wide.
- Operand latches are internal.
- IDLE + `start` + !`flush`:
  - MTHI/MTLO write `a` into HI/LO on the accept edge, pulse `done` the next cycle, and stay in IDLE.
  - MULT/MULTU latch the operands and go to MUL_RUN.
  - DIV/DIVU latch the operands and go to DIV_RUN.
- Signed operations (MULT, DIV) convert operands to magnitudes at accept and apply the sign correction combinationally at the final write.
- MUL_RUN: shift-add, 1 multiplier bit per cycle, 2·WIDTH-bit accumulator. On completion, HI = product[2W-1:W] and LO = product[W-1:0].
- DIV_RUN: restoring division, 1 quotient bit per cycle. LO = quotient, HI = remainder.
  - Quotient truncates toward zero; the remainder takes the dividend's sign.
  - Most-negative ÷ −1 gives LO = most-negative, HI = 0, with no flag.
- Divide by zero: HI = `a`, LO = all ones, `div_by_zero` = 1. It still takes the full latency.
- `div_by_zero` updates on every DIV/DIVU completion and clears on the accept of any other op.
- `start` while `busy` is ignored. The requester must hold the op until `busy`=0.
- `flush` in any state returns the FSM to IDLE on the next edge.
  - No HI/LO write, no `done`, `div_by_zero` unchanged.
  - `flush` has priority over a simultaneous `start`, which is dropped.

## Timing
- Reset values: `busy`=0, `done`=0, `div_by_zero`=0, `HI`=0, `LO`=0, FSM in IDLE, counter 0.
- Reset mid-operation abandons the op; all outputs take their reset values immediately.
- Accept edge E0:
  - `busy`=1 from E0 through E(WIDTH−1).
  - HI/LO are written at edge E_WIDTH.
  - `done`=1 and `busy`=0 in the cycle after E_WIDTH.
- A new op can be accepted at E_WIDTH+1 (back-to-back, with a one-cycle `done` window).
- MTHI/MTLO: HI/LO are visible and `done`=1 in the cycle after E0. `busy` never asserts.
- `done` and `busy` are never high together.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MULT/MULTU use a single-cycle combinational 2·WIDTH product.
  - `busy`=1 for one cycle only (E0 to E1). HI/LO are written at E1 and `done` is high the cycle after E1.
  - DIV timing is unchanged.
- `MULDIV_FAST_MUL_EN` undefined: iterative multiply as specified above. No multiplier array is inferred.

## Test plan
All scenarios use WIDTH=32.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. `busy` high for 32 cycles, then a `done` pulse. With `MULDIV_FAST_MUL_EN`, `done` arrives 1 cycle after accept.
- MULT a=0xFFFFFFFD (−3), b=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. DIV a=0xFFFFFFF9 (−7), b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU a=7, b=0 → HI=7, LO=0xFFFFFFFF, `div_by_zero`=1. A following MTLO 0 clears the flag at accept.
- MTHI a=0x12345678 → HI=0x12345678 the next cycle, `done` pulse, `busy` stays 0, LO unchanged.
- DIV started, `flush` at cycle 10 with `start` asserted → IDLE next cycle, no `done`, HI/LO retain their prior values, and the simultaneous `start` is dropped. A second `start` during a run is ignored until `busy`=0.
- `rst_in` pulsed asynchronously mid-MULTU → HI=LO=0 and `busy`=0 immediately. No `done` follows after release.
